// File: rtl/opm_write_queue_if.sv
// CPU-side write bus and OPM chip pin bundle for the write queue.
interface opm_write_queue_if;
    logic       cpu_wr;
    logic       cpu_a0;
    logic [7:0] cpu_din;
    logic       chip_cs_n;
    logic       chip_wr_n;
    logic       chip_a0;
    logic [7:0] chip_din;

    modport master (
        output cpu_wr, cpu_a0, cpu_din,
        input  chip_cs_n, chip_wr_n, chip_a0, chip_din
    );

    modport slave (
        input  cpu_wr, cpu_a0, cpu_din,
        output chip_cs_n, chip_wr_n, chip_a0, chip_din
    );
endinterface

// File: rtl/opm_write_queue.sv
// Write buffer in front of a jt51 OPM: queues CPU address/data port writes
// and replays them as single-clock strobes separated by chip-ce gaps.
//
// state  | meaning
// IDLE   | pins released, pop head entry when queue not empty
// STROBE | cs_n/wr_n low for one clk, gap counter loaded
// WAIT   | pins released, count down ce pulses until the chip is ready
module opm_write_queue #(
    parameter int DEPTH    = 16,
    parameter int ADDR_GAP = 2,
    parameter int DATA_GAP = 68
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ce,
    opm_write_queue_if.slave           bus,
    input  logic                       flush,
    input  logic                       clr_ovf,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       empty,
    output logic                       full,
    output logic                       busy,
    output logic                       overflow
);
    localparam int LW      = $clog2(DEPTH + 1);
    localparam int PW      = $clog2(DEPTH);
    localparam int GAP_MAX = (DATA_GAP > ADDR_GAP) ? DATA_GAP : ADDR_GAP;
    localparam int GW      = $clog2(GAP_MAX + 1);

    typedef enum logic [1:0] {IDLE, STROBE, WAIT} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [8:0]      mem [DEPTH];
    logic [8:0]      head;
    logic            pop, push, ovf_set;
    logic [LW-1:0]   level_d;
    logic            cs_n_q, cs_n_d;
    logic            a0_q, a0_d;
    logic [7:0]      din_q, din_d;
    logic            busy_d, ovf_d;

    assign head          = mem[rd_ptr];
    assign bus.chip_cs_n = cs_n_q;
    assign bus.chip_wr_n = cs_n_q;
    assign bus.chip_a0   = a0_q;
    assign bus.chip_din  = din_q;

    // Next state and gap counter; a flush in the same cycle suppresses the pop.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !flush) begin
                    pop     = 1'b1;
                    state_d = STROBE;
                end
            end
            STROBE: begin
                gap_d   = a0_q ? GW'(DATA_GAP) : GW'(ADDR_GAP);
                state_d = WAIT;
            end
            WAIT: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else if (ce) begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Queue bookkeeping and next values of the registered outputs.
    always_comb begin
        push    = bus.cpu_wr && !flush && (!full || pop);
        ovf_set = bus.cpu_wr && !flush && full && !pop;
        level_d = flush ? '0 : (level + LW'(push) - LW'(pop));
        cs_n_d  = (state_d != STROBE);
        a0_d    = pop ? head[8]   : a0_q;
        din_d   = pop ? head[7:0] : din_q;
        busy_d  = (state_d != IDLE) || (level_d != '0);
        ovf_d   = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : overflow);
    end

    // State, counter, pointers and all output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            gap_q    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            cs_n_q   <= 1'b1;
            a0_q     <= 1'b0;
            din_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (flush)     wr_ptr <= rd_ptr;
            else if (push) wr_ptr <= wr_ptr + PW'(1);
            level    <= level_d;
            empty    <= (level_d == '0);
            full     <= (level_d == LW'(DEPTH));
            busy     <= busy_d;
            overflow <= ovf_d;
            cs_n_q   <= cs_n_d;
            a0_q     <= a0_d;
            din_q    <= din_d;
        end
    end

    // Entry storage; contents need no reset since level guards every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.cpu_a0, bus.cpu_din};
    end
endmodule
